// File: rtl/rv32i_boot_loader.sv
// Byte-stream boot loader for rv32i_soc: receives a checksummed image frame,
// writes it into SoC memory word by word and releases the core once verified.
module rv32i_boot_loader #(
  parameter int          MEMORY_DEPTH   = 81920,
  parameter logic [31:0] LOAD_ADDR      = 32'h0000_0000,
  parameter logic [7:0]  MAGIC          = 8'hA5,
  parameter int          TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_rx_valid,
  input  logic [7:0]  i_rx_data,
  output logic        o_rx_ready,
  output logic        o_mem_wr_stb,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_ack,
  output logic        o_core_rst,
  output logic        o_done,
  output logic        o_error
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_WRITE, S_CHECK, S_DONE, S_ERROR
  } state_t;

  localparam logic [31:0] MAX_WORDS    = 32'(MEMORY_DEPTH / 4);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_byte_cnt;
  logic [31:0] r_len;
  logic [31:0] r_word;
  logic [31:0] r_index;
  logic [31:0] r_addr;
  logic [7:0]  r_cks;
  logic [31:0] r_timeout;
  logic        r_core_rst;

  logic        w_xfer;
  logic        w_magic;
  logic        w_last_byte;
  logic        w_last_word;
  logic        w_timed_out;
  logic [31:0] w_len_full;

  assign w_xfer      = i_rx_valid & o_rx_ready;
  assign w_magic     = w_xfer && (i_rx_data == MAGIC);
  assign w_last_byte = (r_byte_cnt == 2'd3);
  assign w_last_word = ((r_index + 32'd1) == r_len);
  assign w_timed_out = !w_xfer && (r_timeout == TIMEOUT_LAST);
  assign w_len_full  = {i_rx_data, r_len[23:0]};

  assign o_rx_ready   = (r_state != S_WRITE);
  assign o_mem_wr_stb = (r_state == S_WRITE);
  assign o_mem_addr   = r_addr;
  assign o_mem_wdata  = r_word;
  assign o_core_rst   = r_core_rst;
  assign o_done       = (r_state == S_DONE);
  assign o_error      = (r_state == S_ERROR);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_magic) w_next = S_LEN;
      S_LEN: begin
        if (w_timed_out)                  w_next = S_ERROR;
        else if (w_xfer && w_last_byte) begin
          if (w_len_full > MAX_WORDS)     w_next = S_ERROR;
          else if (w_len_full == 32'd0)   w_next = S_CHECK;
          else                            w_next = S_DATA;
        end
      end
      S_DATA: begin
        if (w_timed_out)                  w_next = S_ERROR;
        else if (w_xfer && w_last_byte)   w_next = S_WRITE;
      end
      S_WRITE: if (i_mem_ack) w_next = w_last_word ? S_CHECK : S_DATA;
      S_CHECK: begin
        if (w_timed_out)                  w_next = S_ERROR;
        else if (w_xfer)                  w_next = (i_rx_data == r_cks) ? S_DONE : S_ERROR;
      end
      S_DONE:  w_next = S_DONE;
      S_ERROR: if (w_magic) w_next = S_LEN;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_byte_cnt <= 2'd0;
      r_len      <= 32'd0;
      r_word     <= 32'd0;
      r_index    <= 32'd0;
      r_addr     <= LOAD_ADDR;
      r_cks      <= 8'd0;
      r_timeout  <= 32'd0;
      r_core_rst <= 1'b1;
    end else begin
      r_state    <= w_next;
      r_core_rst <= (w_next != S_DONE);

      // Idle timer only runs while waiting for frame bytes, never during a memory stall
      if (r_state == S_LEN || r_state == S_DATA || r_state == S_CHECK)
        r_timeout <= w_xfer ? 32'd0 : r_timeout + 32'd1;
      else
        r_timeout <= 32'd0;

      case (r_state)
        S_IDLE, S_ERROR: begin
          if (w_magic) begin
            r_byte_cnt <= 2'd0;
            r_len      <= 32'd0;
            r_index    <= 32'd0;
            r_addr     <= LOAD_ADDR;
            r_cks      <= 8'd0;
          end
        end
        S_LEN: begin
          if (w_xfer) begin
            r_len[{r_byte_cnt, 3'b000} +: 8] <= i_rx_data;
            r_byte_cnt <= r_byte_cnt + 2'd1;
          end
        end
        S_DATA: begin
          if (w_xfer) begin
            r_word[{r_byte_cnt, 3'b000} +: 8] <= i_rx_data;
            r_cks      <= r_cks ^ i_rx_data;
            r_byte_cnt <= r_byte_cnt + 2'd1;
          end
        end
        S_WRITE: begin
          if (i_mem_ack) begin
            r_index <= r_index + 32'd1;
            r_addr  <= r_addr + 32'd4;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/rv32i_boot_loader.md
Name: rv32i_boot_loader

Overview:
- Upstream feeder of rv32i_soc: holds the core in reset while a program image arrives as a byte stream (UART receiver or bench driver).
- Assembles little-endian 32-bit words and writes them into SoC memory through a simple write strobe/ack port.
- Releases the core once a valid checksummed image has been loaded; otherwise reports an error and keeps the core in reset.

Parameters:
- MEMORY_DEPTH, 81920, SoC memory size in bytes; max image = MEMORY_DEPTH/4 words.
- LOAD_ADDR, 32'h0000_0000, byte address of first image word (matches PC_RESET).
- MAGIC, 8'hA5, start-of-frame byte.
- TIMEOUT_CYCLES, 1_000_000, max idle cycles between bytes inside a frame.

Ports:
- i_clk  input  1  system clock.
- i_rst_n  input  1  asynchronous active-low reset.
- i_rx_valid  input  1  byte available.
- i_rx_data  input  8  byte value.
- o_rx_ready  output  1  loader accepts byte; transfer = i_rx_valid & o_rx_ready.
- o_mem_wr_stb  output  1  memory write request, held until acked.
- o_mem_addr  output  32  word-aligned byte address.
- o_mem_wdata  output  32  word to write.
- i_mem_ack  input  1  write accepted this cycle.
- o_core_rst  output  1  active-high reset to rv32i_soc (drives its i_rst).
- o_done  output  1  image loaded and verified.
- o_error  output  1  frame error (timeout, oversize, checksum).

Behaviour:
- Reset values (async, while i_rst_n=0): state IDLE; o_core_rst=1; o_done=0; o_error=0; o_mem_wr_stb=0; o_mem_addr=LOAD_ADDR; o_mem_wdata=0; o_rx_ready=1; all counters and checksum 0.
- Frame format: MAGIC, length N (4 bytes, LE, in words), 4N data bytes (LE per word), 1 checksum byte = XOR of all 4N data bytes (0x00 when N=0).
- States:
  - IDLE: non-MAGIC bytes are discarded. MAGIC -> LEN; clears checksum, word index, byte count, timeout counter.
  - LEN: collects 4 bytes. Then: N > MEMORY_DEPTH/4 -> ERROR; N == 0 -> CHECK; otherwise -> DATA.
  - DATA: byte k of a word goes to bits [8k+7:8k]; every byte is XORed into the checksum. After the 4th byte -> WRITE.
  - WRITE: o_rx_ready=0. o_mem_wr_stb=1, o_mem_addr=LOAD_ADDR+4*index, o_mem_wdata=assembled word, all held stable until i_mem_ack. An ack in the first strobe cycle is legal (1-cycle write). After ack: index+1; if index+1 == N -> CHECK, else -> DATA.
  - CHECK: the next byte is compared with the checksum. Equal -> DONE; not equal -> ERROR.
  - DONE: o_done=1 and o_core_rst=0 from the cycle after the checksum byte is accepted. Terminal until i_rst_n; further bytes are accepted and ignored.
  - ERROR: o_error=1, o_core_rst=1. A MAGIC byte clears o_error and enters LEN (retry). Other bytes are ignored.
- o_rx_ready=1 in every state except WRITE.
- Timeout: in LEN, DATA and CHECK, the counter increments each cycle with no accepted byte and clears on each accepted byte. Reaching TIMEOUT_CYCLES -> ERROR. The counter does not run in WRITE, so memory stalls never time out.
- Words already written before an error stay in memory. The core remains in reset.
- Address arithmetic: 32-bit, no wrap check needed since N is bounded by MEMORY_DEPTH/4.
- Asynchronous reset mid-frame: returns immediately to the reset values. Any outstanding strobe drops without waiting for ack.
- o_core_rst is a registered output (glitch-free).

Test Plan:
- Frame A5, 02 00 00 00, 13 00 00 00, 6F 00 00 00, cks 7C, ack same cycle -> writes 0x00000013 @0x0 and 0x0000006F @0x4; o_done=1 and o_core_rst=0 one cycle after the 0x7C byte.
- Same frame with i_mem_ack delayed 3 cycles per write -> strobe, address and data held stable for 4 cycles; o_rx_ready=0 throughout; identical memory contents and o_done.
- Frame A5, 01 00 00 00, 11 22 33 44, cks 00 (correct is 0x44) -> one write of 0x44332211 @0x0; o_error=1; o_core_rst stays 1. Sending a correct frame afterwards -> o_done=1.
- Length 0x00005001 (> 20480) -> ERROR right after the 4th length byte; no write strobe issued.
- Bytes 00 FF, then A5, 00 00 00 00, 00 -> leading bytes ignored; o_done=1 with zero writes.
- Stop sending after 2 data bytes for TIMEOUT_CYCLES (set to 16) -> o_error=1 at cycle 16. Separately, assert i_rst_n=0 during WRITE -> o_mem_wr_stb=0 and o_core_rst=1 immediately.
